vram_arbiter: RTL and testbench

Arbiter and sequencer for the single-port video memory behind the VGA pipeline. It gives the display scan path absolute priority during active video. It shares the remaining cycles (blanking) between two write requesters: writer 0 is the keyboard console and writer 1 is the UART image loader. Writers are served round-robin with a bounded burst length. The block sits between `vga_ctrl`/the writers and a synchronous-read video RAM, and replaces direct combinational addressing of that RAM.

---
 rtl/vram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display reads own the port during active video,
// blanking cycles go round-robin to two writers. Define VRAM_ARB_STATS_EN for grant/stall counters.
module vram_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 24,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              disp_active,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_rvalid,
    input  logic              w0_req,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_wdata,
    output logic              w0_gnt,
    input  logic              w1_req,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_wdata,
    output logic              w1_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef VRAM_ARB_STATS_EN
    output logic [15:0]       stat_wr0,
    output logic [15:0]       stat_wr1,
    output logic [15:0]       stat_stall,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    owner_e     owner_q, owner_d;
    logic       ptr_q, ptr_d;
    logic [3:0] burst_q, burst_d;
    logic       run_q, run_d;
    logic       rvalid_q, rvalid_d;

    logic       rd;
    logic       gvalid;
    logic       gsel;
    logic       cur, cur_req, oth_req;

    // run_q clears asynchronously with resetn but only sets on a clock edge,
    // so every output is suppressed at once and released synchronously.
    assign run_d = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q    <= 1'b0;
            owner_q  <= IDLE;
            ptr_q    <= 1'b0;
            burst_q  <= 4'd0;
            rvalid_q <= 1'b0;
        end else begin
            run_q    <= run_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            burst_q  <= burst_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        gvalid  = 1'b0;
        gsel    = 1'b0;
        cur     = (owner_q == OWN1);
        cur_req = cur ? w1_req : w0_req;
        oth_req = cur ? w0_req : w1_req;
        rd      = run_q & disp_active;

        if (run_q && !disp_active) begin
            case (owner_q)
                OWN0, OWN1: begin
                    if (cur_req && burst_q < MAX_B) begin
                        gvalid  = 1'b1;
                        gsel    = cur;
                        burst_d = burst_q + 4'd1;
                    end else if (oth_req) begin
                        gvalid  = 1'b1;
                        gsel    = ~cur;
                        burst_d = 4'd1;
                    end else if (cur_req) begin
                        // burst exhausted but nobody else wants the port
                        gvalid  = 1'b1;
                        gsel    = cur;
                        burst_d = 4'd1;
                    end else begin
                        owner_d = IDLE;
                        burst_d = 4'd0;
                    end
                end
                default: begin
                    if (w0_req || w1_req) begin
                        gvalid  = 1'b1;
                        gsel    = (w0_req && w1_req) ? ptr_q : w1_req;
                        burst_d = 4'd1;
                    end else begin
                        owner_d = IDLE;
                        burst_d = 4'd0;
                    end
                end
            endcase
            if (gvalid) begin
                owner_d = gsel ? OWN1 : OWN0;
                ptr_d   = ~gsel;
            end
        end
    end

    assign rvalid_d = rd;

    always_comb begin
        mem_en    = rd | gvalid;
        mem_we    = gvalid;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd) begin
            mem_addr = disp_addr;
        end else if (gvalid) begin
            mem_addr  = gsel ? w1_addr : w0_addr;
            mem_wdata = gsel ? w1_wdata : w0_wdata;
        end
    end

    assign w0_gnt      = gvalid & ~gsel;
    assign w1_gnt      = gvalid & gsel;
    assign disp_rvalid = rvalid_q;
    assign disp_data   = rvalid_q ? mem_rdata : '0;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stat_wr0_q, stat_wr0_d;
    logic [15:0] stat_wr1_q, stat_wr1_d;
    logic [15:0] stat_stall_q, stat_stall_d;
    logic        stall;

    assign stall = run_q & (w0_req | w1_req) & ~gvalid;

    always_comb begin
        stat_wr0_d   = stat_wr0_q;
        stat_wr1_d   = stat_wr1_q;
        stat_stall_d = stat_stall_q;
        if (w0_gnt && stat_wr0_q != 16'hffff)
            stat_wr0_d = stat_wr0_q + 16'd1;
        if (w1_gnt && stat_wr1_q != 16'hffff)
            stat_wr1_d = stat_wr1_q + 16'd1;
        if (stall && stat_stall_q != 16'hffff)
            stat_stall_d = stat_stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_wr0_q   <= 16'd0;
            stat_wr1_q   <= 16'd0;
            stat_stall_q <= 16'd0;
        end else begin
            stat_wr0_q   <= stat_wr0_d;
            stat_wr1_q   <= stat_wr1_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_wr0   = stat_wr0_q;
    assign stat_wr1   = stat_wr1_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle vector table plus hand sequences
// for reset release, mid-burst reset and (optionally) the statistics counters.
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 24;
    localparam logic [AW-1:0] W0A = 19'h0A5A0;
    localparam logic [AW-1:0] W1A = 19'h1B3C4;
    localparam logic [DW-1:0] W0D = 24'hAAAA01;
    localparam logic [DW-1:0] W1D = 24'h555502;
    localparam logic [DW-1:0] RD_OFS = 24'h100000;

    logic          clk = 1'b0;
    logic          resetn;
    logic          disp_active;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_rvalid;
    logic          w0_req, w1_req, w0_gnt, w1_gnt;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   stat_wr0, stat_wr1, stat_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk(clk), .resetn(resetn),
        .disp_active(disp_active), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_rvalid(disp_rvalid),
        .w0_req(w0_req), .w0_addr(W0A), .w0_wdata(W0D), .w0_gnt(w0_gnt),
        .w1_req(w1_req), .w1_addr(W1A), .w1_wdata(W1D), .w1_gnt(w1_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef VRAM_ARB_STATS_EN
        .stat_wr0(stat_wr0), .stat_wr1(stat_wr1), .stat_stall(stat_stall),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM whose contents are a known function of the address
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= RD_OFS + {5'd0, mem_addr};
    end

    typedef struct {
        logic          da;
        logic [AW-1:0] daddr;
        logic          r0, r1;
        logic          g0, g1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic da, input logic [AW-1:0] daddr, input logic r0, input logic r1,
                       input logic g0, input logic g1);
        vec_t v;
        v.da = da; v.daddr = daddr; v.r0 = r0; v.r1 = r1; v.g0 = g0; v.g1 = g1;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic r0, input logic r1, input logic g0, input logic g1);
        for (int i = 0; i < n; i++) add(1'b0, '0, r0, r1, g0, g1);
    endtask

    task automatic drive(input logic da, input logic [AW-1:0] daddr, input logic r0, input logic r1);
        @(negedge clk);
        disp_active = da; disp_addr = daddr; w0_req = r0; w1_req = r1;
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_g0"}, {31'd0, w0_gnt}, 32'd0);
        check({tag, "_g1"}, {31'd0, w1_gnt}, 32'd0);
        check({tag, "_en"}, {31'd0, mem_en}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, {13'd0, mem_addr}, 32'd0);
        check({tag, "_wdata"}, {8'd0, mem_wdata}, 32'd0);
    endtask

    initial begin
        logic          prev_da;
        logic [AW-1:0] prev_addr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd, exp_rd;
        string         nm;

        resetn = 1'b0; disp_active = 1'b1; disp_addr = 19'h00077; w0_req = 1'b1; w1_req = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_quiet("rst");
        check("rst_rvalid", {31'd0, disp_rvalid}, 32'd0);
        check("rst_data", {8'd0, disp_data}, 32'd0);

        // release: first edge only lifts reset, the next cycle grants
        @(negedge clk);
        resetn = 1'b1; disp_active = 1'b0;
        #2;
        check_quiet("rel");
        drive(1'b0, '0, 1'b1, 1'b0);
        check("rel_g0", {31'd0, w0_gnt}, 32'd1);
        check("rel_we", {31'd0, mem_we}, 32'd1);
        check("rel_addr", {13'd0, mem_addr}, {13'd0, W0A});
        drive(1'b0, '0, 1'b0, 1'b0);
        check_quiet("rel_idle");

        // display priority (ptr now favours w1)
        add(1'b1, 19'h00123, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 19'h00124, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, '0,        1'b0, 1'b1, 1'b0, 1'b1);
        add_n(1, 1'b0, 1'b0, 1'b0, 1'b0);
        // saturating fairness: 0000 1111 0
        add_n(4, 1'b1, 1'b1, 1'b1, 1'b0);
        add_n(4, 1'b1, 1'b1, 1'b0, 1'b1);
        add_n(1, 1'b1, 1'b1, 1'b1, 1'b0);
        // display mid-burst holds burst count
        add(1'b1, 19'h00200, 1'b1, 1'b1, 1'b0, 1'b0);
        add_n(3, 1'b1, 1'b1, 1'b1, 1'b0);
        add_n(1, 1'b1, 1'b1, 1'b0, 1'b1);
        add_n(1, 1'b0, 1'b0, 1'b0, 1'b0);
        // tie from idle after a w0 grant goes to w1
        add_n(1, 1'b1, 1'b0, 1'b1, 1'b0);
        add_n(1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_n(1, 1'b1, 1'b1, 1'b0, 1'b1);
        add_n(1, 1'b0, 1'b0, 1'b0, 1'b0);
        // lone writer: no gap when the burst counter rolls over
        add_n(10, 1'b0, 1'b1, 1'b0, 1'b1);
        add_n(1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_n(1, 1'b1, 1'b0, 1'b1, 1'b0);
        add_n(1, 1'b1, 1'b1, 1'b1, 1'b0);

        prev_da = 1'b0; prev_addr = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].da, vecs[i].daddr, vecs[i].r0, vecs[i].r1);
            nm = $sformatf("v%0d", i);
            exp_addr = vecs[i].da ? vecs[i].daddr : vecs[i].g0 ? W0A : vecs[i].g1 ? W1A : '0;
            exp_wd   = vecs[i].da ? '0 : vecs[i].g0 ? W0D : vecs[i].g1 ? W1D : '0;
            exp_rd   = prev_da ? RD_OFS + {5'd0, prev_addr} : '0;
            check({nm, "_g0"}, {31'd0, w0_gnt}, {31'd0, vecs[i].g0});
            check({nm, "_g1"}, {31'd0, w1_gnt}, {31'd0, vecs[i].g1});
            check({nm, "_en"}, {31'd0, mem_en}, {31'd0, vecs[i].da | vecs[i].g0 | vecs[i].g1});
            check({nm, "_we"}, {31'd0, mem_we}, {31'd0, vecs[i].g0 | vecs[i].g1});
            check({nm, "_addr"}, {13'd0, mem_addr}, {13'd0, exp_addr});
            if (!vecs[i].da) check({nm, "_wdata"}, {8'd0, mem_wdata}, {8'd0, exp_wd});
            check({nm, "_rvalid"}, {31'd0, disp_rvalid}, {31'd0, prev_da});
            check({nm, "_data"}, {8'd0, disp_data}, {8'd0, exp_rd});
            prev_da = vecs[i].da; prev_addr = vecs[i].daddr;
        end

        // reset asserted mid-burst kills the grant immediately; restart favours w0
        drive(1'b0, '0, 1'b1, 1'b1);
        check("mid_g0_before", {31'd0, w0_gnt}, 32'd1);
        resetn = 1'b0;
        #1;
        check_quiet("mid_rst");
        @(negedge clk);
        resetn = 1'b1;
        #2;
        check_quiet("mid_rel");
        drive(1'b0, '0, 1'b1, 1'b1);
        check("mid_restart_g0", {31'd0, w0_gnt}, 32'd1);
        check("mid_restart_g1", {31'd0, w1_gnt}, 32'd0);

`ifdef VRAM_ARB_STATS_EN
        drive(1'b0, '0, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        check("st_rst_wr0", {16'd0, stat_wr0}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
        repeat (5) drive(1'b1, 19'h00010, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("st_wr0", {16'd0, stat_wr0}, 32'd3);
        check("st_wr1", {16'd0, stat_wr1}, 32'd0);
        check("st_stall", {16'd0, stat_stall}, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
